// File: rtl/io_input_responder.sv
// Peripheral responder for the CPU IN instruction: stalls the CPU until a fresh
// debounced button press, then returns the synchronized switch value with a one-cycle ack.
module io_input_responder #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        botaoPlaca,
    input  logic [3:0]  entradaDeDadosIO,
    input  logic        req_in,
    output logic [31:0] dado_in,
    output logic        ack_in,
    output logic        pausa,
    output logic        botao_estavel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FREE = 2'd1,
        ARMED     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t          state_r;
    logic            s1_r, s2_r;
    logic [3:0]      sw1_r, sw2_r;
    logic            stable_r, stable_d_r;
    logic [CW-1:0]   cnt_r;
    logic            press_evt_r;

    // Two-flop synchronizers for the asynchronous button and switch pins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            sw1_r <= 4'd0;
            sw2_r <= 4'd0;
        end else begin
            s1_r  <= botaoPlaca;
            s2_r  <= s1_r;
            sw1_r <= entradaDeDadosIO;
            sw2_r <= sw1_r;
        end
    end

    // Debounce counter and rising-edge press detector; any bounce restarts the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_r    <= 1'b0;
            stable_d_r  <= 1'b0;
            cnt_r       <= '0;
            press_evt_r <= 1'b0;
        end else begin
            stable_d_r  <= stable_r;
            press_evt_r <= stable_r & ~stable_d_r;
            if (s2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= s2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Request FSM with registered data capture and ack pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            dado_in <= 32'd0;
            ack_in  <= 1'b0;
        end else begin
            ack_in <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_in) begin
                        state_r <= stable_r ? WAIT_FREE : ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_FREE: begin
                    if (!req_in) begin
                        state_r <= IDLE;
                    end else if (!stable_r) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= WAIT_FREE;
                    end
                end
                ARMED: begin
                    // Dropping the request aborts silently; a coincident press is lost
                    if (!req_in) begin
                        state_r <= IDLE;
                    end else if (press_evt_r) begin
                        dado_in <= {28'd0, sw2_r};
                        ack_in  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                DONE: begin
                    state_r <= req_in ? DONE : IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign pausa         = req_in & (state_r != DONE);
    assign botao_estavel = stable_r;

endmodule

// File: tb/tb_io_input_responder.sv
// Directed self-checking bench for io_input_responder with DEBOUNCE_CYCLES = 4.
module tb_io_input_responder;

    logic        clock;
    logic        reset;
    logic        botaoPlaca;
    logic [3:0]  entradaDeDadosIO;
    logic        req_in;
    logic [31:0] dado_in;
    logic        ack_in;
    logic        pausa;
    logic        botao_estavel;

    int n_checks = 0;
    int n_errors = 0;

    io_input_responder #(.DEBOUNCE_CYCLES(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .botaoPlaca       (botaoPlaca),
        .entradaDeDadosIO (entradaDeDadosIO),
        .req_in           (req_in),
        .dado_in          (dado_in),
        .ack_in           (ack_in),
        .pausa            (pausa),
        .botao_estavel    (botao_estavel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Button already driven high; ack expected exactly at edge index 'at' after e0
    task automatic run_press(input string tag, input logic [31:0] exp_dado, input int at, input int n);
        int acks;
        acks = 0;
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (ack_in === 1'b1) acks++;
            check({tag, "_ack"}, {31'd0, ack_in}, {31'd0, (k == at)});
            check({tag, "_pausa"}, {31'd0, pausa}, {31'd0, (k < at)});
            if (k == at) check({tag, "_dado"}, dado_in, exp_dado);
        end
        check({tag, "_ack_count"}, acks, 32'd1);
    endtask

    initial begin
        logic [6:0] bounce;
        bounce           = 7'b0111011;   // bit k = sample at edge k: 1,1,0,1,1,1,0
        reset            = 1'b0;
        botaoPlaca       = 1'b0;
        entradaDeDadosIO = 4'h0;
        req_in           = 1'b1;
        #12;
        check("rst_dado", dado_in, 32'd0);
        check("rst_ack", {31'd0, ack_in}, 32'd0);
        check("rst_estavel", {31'd0, botao_estavel}, 32'd0);
        check("rst_pausa", {31'd0, pausa}, 32'd1);
        reset = 1'b1;

        // Clean press
        entradaDeDadosIO = 4'hA;
        tick(3);
        botaoPlaca = 1'b1;
        run_press("clean", 32'h0000000A, 7, 20);

        // Release, then bounce
        req_in     = 1'b0;
        botaoPlaca = 1'b0;
        tick(8);
        check("release_estavel", {31'd0, botao_estavel}, 32'd0);
        entradaDeDadosIO = 4'h6;
        req_in = 1'b1;
        tick(2);
        for (int k = 0; k < 20; k++) begin
            botaoPlaca = (k < 7) ? bounce[k] : 1'b1;
            tick(1);
            check("bounce_ack", {31'd0, ack_in}, {31'd0, (k == 14)});
            if (k == 14) check("bounce_dado", dado_in, 32'd6);
        end

        // Held before request
        req_in = 1'b0;
        tick(3);
        check("held_estavel", {31'd0, botao_estavel}, 32'd1);
        req_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("held_noack", {31'd0, ack_in}, 32'd0);
            check("held_pausa", {31'd0, pausa}, 32'd1);
        end
        entradaDeDadosIO = 4'h3;
        botaoPlaca = 1'b0;
        tick(8);
        check("held_rel_ack", {31'd0, ack_in}, 32'd0);
        botaoPlaca = 1'b1;
        run_press("held", 32'd3, 7, 12);

        // Abort
        req_in     = 1'b0;
        botaoPlaca = 1'b0;
        tick(8);
        req_in = 1'b1;
        tick(2);
        req_in = 1'b0;
        tick(1);
        check("abort_pausa", {31'd0, pausa}, 32'd0);
        botaoPlaca = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            check("abort_noack", {31'd0, ack_in}, 32'd0);
        end
        check("abort_dado", dado_in, 32'd3);
        check("abort_estavel", {31'd0, botao_estavel}, 32'd1);
        botaoPlaca = 1'b0;
        tick(8);

        // Reset mid-operation
        req_in = 1'b1;
        tick(2);
        botaoPlaca = 1'b1;
        tick(4);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ack", {31'd0, ack_in}, 32'd0);
        check("midrst_dado", dado_in, 32'd0);
        check("midrst_estavel", {31'd0, botao_estavel}, 32'd0);
        botaoPlaca = 1'b0;
        #3;
        reset = 1'b1;
        entradaDeDadosIO = 4'h5;
        tick(3);
        botaoPlaca = 1'b1;
        run_press("req1", 32'd5, 7, 20);

        // Second request
        req_in     = 1'b0;
        botaoPlaca = 1'b0;
        entradaDeDadosIO = 4'hF;
        tick(8);
        req_in = 1'b1;
        tick(2);
        botaoPlaca = 1'b1;
        run_press("req2", 32'd15, 7, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_input_responder.md
# io_input_responder

Peripheral-side responder for the CPU `IN` instruction. While the CPU holds an input request, it stalls the processor, waits for a fresh debounced press of the board button, and captures the 4-bit switch value. It then returns that value zero-extended to 32 bits with a one-cycle acknowledge. It sits between the board pins (`botaoPlaca`, `entradaDeDadosIO`) and the CPU IO/halt path, and supplies the button debounce that the input path requires.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive synchronized samples at a new level needed to accept a button change; legal range ≥ 1.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately when low.
- `botaoPlaca` in 1: raw board button, asynchronous, high = pressed.
- `entradaDeDadosIO` in 4: raw switch value, asynchronous.
- `req_in` in 1: level from the CPU, high while an `IN` instruction is pending.
- `dado_in` out 32: captured value `{28'b0, switches}`; holds until the next capture.
- `ack_in` out 1: one-cycle pulse, high in the cycle `dado_in` first shows the new value.
- `pausa` out 1: stall request to the CPU halt logic.
- `botao_estavel` out 1: debounced button level, for debug/LED use.

## Operation
- **Synchronizers.** Two-flop synchronizer on `botaoPlaca` (s1, s2). Two-flop synchronizer on `entradaDeDadosIO` (4 bits, sw1, sw2).
- **Debounce.**
  - Registers: `stable` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If s2 == `stable`: `cnt` <= 0.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: `stable` <= s2 and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any bounce back to the `stable` level restarts the count. `botao_estavel` = `stable`.
- **Press detection.** `press_evt` is a registered one-cycle pulse, high in the cycle after `stable` goes 0→1. Releases generate no event.
- **FSM states.** IDLE, WAIT_FREE, ARMED, DONE.
  - IDLE: if `req_in` and `stable`=1, go to WAIT_FREE. If `req_in` and `stable`=0, go to ARMED.
  - WAIT_FREE: the button was already held when the request arrived; a fresh press is required. If `req_in`=0, go to IDLE. Else if `stable`=0, go to ARMED.
  - ARMED: if `req_in`=0, go to IDLE. This is an abort, e.g. a context switch: no ack, `dado_in` unchanged. Else if `press_evt`, then on that edge `dado_in` <= `{28'b0, sw2}`, `ack_in` <= 1, and go to DONE.
  - DONE: `ack_in` <= 0. When `req_in`=0, go to IDLE. Presses are ignored while in DONE.
- **Stall.** `pausa` is combinational: `req_in` AND state ∈ {IDLE, WAIT_FREE, ARMED}. It is therefore low in the same cycle `ack_in` is high.
- **No buffering.** Presses in IDLE or DONE are discarded. A press event at the same edge as an abort is discarded.
- **Reset values (reset low).** State IDLE; s1, s2, sw1, sw2, `stable`, `cnt`, `press_evt`, `ack_in` all 0; `dado_in` = 0. Consequently `pausa` = `req_in`, and `botao_estavel` = 0.
- **Button held through reset release.** It is debounced as a new press, but is ignored unless the FSM is in ARMED. On a new `req_in` it leads to WAIT_FREE.

## Timing
- Press latency, with the FSM in ARMED and a clean press: edge e0 is the first edge sampling `botaoPlaca`=1.
  - s2 = 1 after e1.
  - `stable` = 1 after e(DEBOUNCE_CYCLES+1).
  - `press_evt` after e(DEBOUNCE_CYCLES+2).
  - `ack_in`=1 and new `dado_in` after e(DEBOUNCE_CYCLES+3).
- Switch value used is sw2 at the capture edge, which is the switch pin state 2 edges earlier. Switches must be stable before the press.
- `ack_in` is high for exactly one cycle per accepted request.
- Release debounce: `stable` falls DEBOUNCE_CYCLES+1 edges after the first edge sampling 0.
- Back-to-back requests: the CPU deasserts `req_in` for ≥1 cycle between requests (DONE→IDLE). If `req_in` is held high after an ack, no second ack is issued.

## Test plan
- **Clean press:** DEBOUNCE_CYCLES=4, reset, `req_in`=1, switches=4'hA, press held 20 cycles → `pausa`=1 until ack; `ack_in` pulses exactly once, 7 edges after the first high sample; `dado_in`=32'h0000000A; `pausa`=0 in the ack cycle.
- **Bounce:** DEBOUNCE_CYCLES=4, `req_in`=1, button pattern 1,1,0,1,1,1,0 then steady 1 → no ack before the steady run; ack 7 edges after the start of the steady run.
- **Held before request:** button stable-pressed, then `req_in`=1 → WAIT_FREE, no ack. Release, then press again with switches=4'h3 → one ack, `dado_in`=3.
- **Abort:** ARMED, `req_in` dropped before the press → no ack, `dado_in` keeps its prior value, `pausa`=0. A later press while IDLE produces no ack.
- **Reset mid-operation:** ARMED with `cnt`=2, assert `reset` low asynchronously mid-cycle → `ack_in`=0, `dado_in`=0, `botao_estavel`=0 immediately. After release with `req_in`=1, the FSM returns to ARMED.
- **Two requests:** `req_in` 1→ack→0→1 with switches 4'h5 then 4'hF → two single-cycle acks, `dado_in` 5 then 15.
